aes_round_ctrl: RTL
===================

Name: aes_round_ctrl

Overview:
- Sequencer for the AES-128 round datapath: the AddRoundKey XOR stage plus the SubBytes, ShiftRows and MixColumns units.
- Issues round-key reads to the key memory and drives per-cycle enables so the datapath performs the initial AddRoundKey, NR-1 full rounds and a final round without MixColumns.
- Supports encryption (keys read ascending) and decryption (keys read descending).
- Sits beside the datapath in the Versat accelerator and uses a run/done handshake.

Parameters:
- NR, 10: number of AES rounds.
- KEY_ADDR_W, 4: key memory address width. 2^KEY_ADDR_W must be > NR; the bench checks this.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- run  input  1  start request; sampled in IDLE or DONE.
- dec  input  1  1 = decrypt key order; latched when run is accepted.
- abort  input  1  synchronous cancel of an operation in progress.
- state_load  output  1  datapath loads input block into state register.
- key_ren  output  1  key memory read enable. Key data is valid 1 cycle later.
- key_addr  output  KEY_ADDR_W  round-key address.
- ark_en  output  1  state <= state XOR key_rdata (AddRoundKey capture).
- sub_en  output  1  SubBytes/ShiftRows stage enable.
- mix_en  output  1  MixColumns enable. Low in the final round.
- round  output  KEY_ADDR_W  current round index r, 0..NR.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  one-cycle pulse when the result is valid.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE, r = 0, latched dec = 0.
  - All outputs read 0.
  - Applies at any time, including mid-operation. The operation is lost and no done is produced.
- States: IDLE, LOAD, ARK, RND, DONE.
- IDLE: all outputs 0. If run = 1: latch dec, set r = 0, go to LOAD.
- LOAD (1 cycle):
  - Outputs: state_load = 1, key_ren = 1, key_addr = kaddr(0).
  - Next state: ARK.
- ARK (1 cycle):
  - Output: ark_en = 1.
  - If r == NR: go to DONE. Otherwise r <= r+1 and go to RND.
- RND (1 cycle):
  - Outputs: sub_en = 1; mix_en = (r != NR); key_ren = 1; key_addr = kaddr(r).
  - Next state: ARK.
- DONE (1 cycle):
  - Output: done = 1.
  - If run = 1: latch dec, r = 0, go to LOAD (back-to-back operation). Otherwise go to IDLE.
- Key address: kaddr(r) = r when dec = 0, and NR - r when dec = 1. Width is KEY_ADDR_W; it never wraps because NR < 2^KEY_ADDR_W.
- round output = r in all states; it reads 0 in IDLE.
- Latency:
  - run accepted at clock edge E0 puts LOAD in the cycle after E0.
  - done is high in cycle 2*NR+3 counting LOAD as cycle 1. That is cycle 23 for NR = 10.
  - Throughput is one block per 2*NR+3 cycles.
- run in LOAD, ARK or RND: ignored. dec changes in those states are also ignored.
- abort = 1 in LOAD, ARK or RND: next state is IDLE and r = 0. No done, no further enables.
- abort has priority over normal transitions. It has no effect in IDLE or DONE.
- run and abort both high in IDLE: run wins; abort is ignored there.
- Outputs are Moore: decoded from registered state, r and latched dec only. No input-to-output combinational path.

Test Plan:
- Encrypt, NR = 10: rst released, run = 1 for 1 cycle with dec = 0.
  -> key_addr sequence 0,1,...,10 on key_ren cycles.
  -> 11 ark_en pulses.
  -> mix_en high in rounds 1-9, low in round 10.
  -> done high in cycle 23 only; busy high in cycles 1-22.
- Decrypt: run with dec = 1, then toggle dec mid-operation.
  -> key_addr sequence 10,9,...,0 unaffected by the toggle.
  -> done at cycle 23.
- Back-to-back: run held high continuously.
  -> done every 23 cycles and LOAD immediately follows each DONE.
  -> extra run pulses during busy start nothing.
- Abort: abort = 1 during RND with r = 4.
  -> next cycle IDLE with all outputs 0; no done ever.
  -> a subsequent run restarts at key_addr 0.
- Reset mid-operation: rst low during ARK with r = 7, asynchronous to clk.
  -> outputs 0 immediately, before the next edge.
  -> after release, IDLE until run.
- Load-stage checks: in LOAD, state_load = 1 and key_ren = 1 in the same cycle; ark_en is first asserted in the following cycle.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for an AES-128 round datapath.
// Runs the initial AddRoundKey, NR-1 full rounds and a final round without
// MixColumns. It issues round-key reads (ascending for encrypt, descending
// for decrypt) and drives the per-cycle datapath enables.
//
// Handshake: run is sampled only in IDLE or DONE. Each accepted run yields
// exactly one done pulse, 2*NR+3 cycles after LOAD starts (LOAD counts as
// cycle 1), unless abort or reset cancels the operation first. Holding run
// high in DONE starts the next block immediately.
// All outputs are registered. Each is decoded from the next state, the next
// round index and the next latched dec, so it follows the current state with
// no combinational path from an input to an output.
module aes_round_ctrl #(
  parameter int NR         = 10,
  parameter int KEY_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  dec,
  input  logic                  abort,
  output logic                  state_load,
  output logic                  key_ren,
  output logic [KEY_ADDR_W-1:0] key_addr,
  output logic                  ark_en,
  output logic                  sub_en,
  output logic                  mix_en,
  output logic [KEY_ADDR_W-1:0] round,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ARK  = 3'd2,
    S_RND  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [KEY_ADDR_W-1:0] NR_A = KEY_ADDR_W'(NR);

  state_t                  state, state_nx;
  logic [KEY_ADDR_W-1:0]   r, r_nx;
  logic                    dec_q, dec_nx;

  // Outputs decoded from the next-state values, captured by the state register.
  logic                    state_load_nx, key_ren_nx, ark_en_nx, sub_en_nx;
  logic                    mix_en_nx, busy_nx, done_nx;
  logic [KEY_ADDR_W-1:0]   key_addr_nx;

  // Round-key address. It does not wrap because NR < 2**KEY_ADDR_W.
  function automatic logic [KEY_ADDR_W-1:0] kaddr(input logic [KEY_ADDR_W-1:0] rr,
                                                  input logic d);
    return d ? (NR_A - rr) : rr;
  endfunction

  // Next-state logic. abort cancels LOAD, ARK and RND and returns r to 0.
  always_comb begin
    state_nx = state;
    r_nx     = r;
    dec_nx   = dec_q;
    case (state)
      S_IDLE: begin
        if (run) begin
          dec_nx   = dec;
          r_nx     = '0;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          r_nx     = '0;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_ARK;
        end
      end
      S_ARK: begin
        if (abort) begin
          r_nx     = '0;
          state_nx = S_IDLE;
        end else if (r == NR_A) begin
          state_nx = S_DONE;
        end else begin
          r_nx     = r + KEY_ADDR_W'(1);
          state_nx = S_RND;
        end
      end
      S_RND: begin
        if (abort) begin
          r_nx     = '0;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_ARK;
        end
      end
      S_DONE: begin
        r_nx = '0;
        if (run) begin
          dec_nx   = dec;
          state_nx = S_LOAD;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        r_nx     = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state. key_addr is forced to 0 whenever
  // key_ren is low, so IDLE reads all-zero.
  always_comb begin
    state_load_nx = (state_nx == S_LOAD);
    key_ren_nx    = (state_nx == S_LOAD) || (state_nx == S_RND);
    key_addr_nx   = key_ren_nx ? kaddr(r_nx, dec_nx) : '0;
    ark_en_nx     = (state_nx == S_ARK);
    sub_en_nx     = (state_nx == S_RND);
    mix_en_nx     = (state_nx == S_RND) && (r_nx != NR_A);
    busy_nx       = (state_nx == S_LOAD) || (state_nx == S_ARK) || (state_nx == S_RND);
    done_nx       = (state_nx == S_DONE);
  end

  // State register and registered outputs. An asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      r          <= '0;
      dec_q      <= 1'b0;
      state_load <= 1'b0;
      key_ren    <= 1'b0;
      key_addr   <= '0;
      ark_en     <= 1'b0;
      sub_en     <= 1'b0;
      mix_en     <= 1'b0;
      round      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      state_dbg  <= 3'd0;
    end else begin
      state      <= state_nx;
      r          <= r_nx;
      dec_q      <= dec_nx;
      state_load <= state_load_nx;
      key_ren    <= key_ren_nx;
      key_addr   <= key_addr_nx;
      ark_en     <= ark_en_nx;
      sub_en     <= sub_en_nx;
      mix_en     <= mix_en_nx;
      round      <= r_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      state_dbg  <= state_nx;
    end
  end

endmodule
